fifo_burst_reader: RTL and testbench
====================================

// Module: fifo_burst_reader
// PURPOSE
//  Consumer-side controller for a FIFO_if fifo: drains a commanded burst of LEN words.
//  Pops words from the FIFO head into a 1-deep output register.
//  Presents each word to the systolic-array edge on a valid/ready stream.
//  One instance per array row/column feed; pairs with the fifo that buffers operand data.
// PARAMETERS
//  MAX_LEN  256  largest burst length; counter width LW = $clog2(MAX_LEN+1)
// PORTS
//  clk         input   1      system clock, all logic on posedge
//  RST         input   1      synchronous, active-high reset
//  start       input   1      burst request; sampled only in IDLE
//  len         input   LW     burst length in words, 0..MAX_LEN; sampled with start
//  fifo_dat    input   word_t FIFO head word (fifoif.dat_out), valid when !fifo_empty
//  fifo_empty  input   1      fifoif.is_empty
//  fifo_pop    output  1      fifoif.pop; combinational, asserted only when a pop is taken
//  out_data    output  word_t registered word to array
//  out_valid   output  1      out_data valid
//  out_ready   input   1      array accepts out_data this cycle
//  busy        output  1      high in RUN and DONE
//  done        output  1      1-cycle pulse when the last word of a burst is accepted
//  stall_cnt   output  16     empty-stall cycles of current burst (see CONFIGURATION)
// BEHAVIOUR
//  Reset (RST=1 at posedge):
//   - state=IDLE; out_valid=0, out_data=0, remain=0, done=0, busy=0, stall_cnt=0.
//   - fifo_pop=0 while RST=1; no pop is taken during a reset cycle.
//   - Reset mid-burst abandons the burst: an undelivered out_data word is dropped; FIFO contents are untouched.
//  FSM IDLE -> RUN -> DONE -> IDLE:
//   - IDLE, start=1, len>0: remain<=len, go RUN.
//   - IDLE, start=1, len=0: go DONE directly; no pops.
//   - start is ignored outside IDLE.
//   - RUN: take = remain!=0 & !fifo_empty & (!out_valid | out_ready).
//     fifo_pop = take. On take: out_data<=fifo_dat, out_valid<=1, remain<=remain-1.
//   - RUN: out_valid & out_ready & !take -> out_valid<=0.
//   - RUN -> DONE when remain==0 and (out_valid==0 or out_ready==1); the last word is accepted that cycle.
//   - DONE: done=1 for exactly one cycle, out_valid=0, then IDLE. busy=1 in RUN and DONE.
//  Throughput and latency:
//   - Full throughput: with FIFO non-empty and out_ready held high, 1 word/cycle; pop and accept in the same cycle.
//   - Latency: pop in cycle N -> out_valid in cycle N+1.
//   - First pop can occur in the cycle after start.
//  Hold and ordering:
//   - out_data is stable while out_valid & !out_ready.
//   - Word order equals pop order; no word is duplicated or skipped.
//  Boundaries:
//   - FIFO empty in RUN: no pop; out_valid drops once the held word is accepted; resumes when non-empty.
//   - out_ready low with out_valid=1: no pop (FIFO never over-read).
//   - Exactly len pops per burst; extra FIFO words remain queued.
//   - remain arithmetic in LW bits, never decremented below 0.
// CONFIGURATION
//  Macro BURST_STALL_CNT_EN:
//   - Defined: stall_cnt increments each RUN cycle with remain!=0 & fifo_empty.
//     16-bit, saturates at 16'hFFFF, cleared on accepted start, held after burst until next start.
//   - Not defined: stall_cnt tied to 16'h0; no counter logic.
// TESTING
//  1. FIFO holds 4 words A,B,C,D; start len=4, out_ready=1 -> pops cycles 1-4;
//     out_valid cycles 2-5 carrying A..D; done at cycle 6; FIFO empty.
//  2. FIFO holds 8 words; start len=3, out_ready=1 -> exactly 3 pops, done once, FIFO ocp=5.
//  3. len=4, out_ready low for 3 cycles after first word -> out_data holds A, fifo_pop=0 those cycles;
//     B,C,D follow in order; done after D accepted.
//  4. len=3, FIFO empty for 5 cycles after first word ->
//     out_valid=0 after A accepted, no pops, resume on push;
//     stall_cnt=5 with BURST_STALL_CNT_EN, 0 without.
//  5. start len=0 -> no pops, done pulse 1 cycle after start; start pulsed in RUN -> ignored, remain unchanged.
//  6. RST=1 mid-burst with out_valid=1 -> next cycle IDLE, out_valid=0, busy=0, fifo_pop=0; FIFO ocp unchanged.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Consumer-side controller for a FIFO: drains a commanded burst of `len`
//   words from the FIFO head into a 1-deep output register and presents each
//   word on a valid/ready stream toward the systolic-array edge. One instance
//   feeds one array row or column.
//
// Optional feature (compile-time macro BURST_STALL_CNT_EN):
//   defined     -> stall_cnt counts RUN cycles spent waiting on an empty FIFO
//                  while words are still owed (16-bit, saturating, cleared on
//                  an accepted start, held after the burst).
//   not defined -> stall_cnt is tied to zero and no counter exists.
//
// Parameters
//   MAX_LEN   largest burst length; LW = $clog2(MAX_LEN+1) is the length width
//   DW        data word width
//
// Ports
//   clk         system clock, all logic on posedge
//   RST         synchronous, active-high reset
//   start       burst request, sampled only in IDLE
//   len         burst length in words (0..MAX_LEN), sampled with start
//   fifo_dat    FIFO head word, valid when !fifo_empty
//   fifo_empty  FIFO empty flag
//   fifo_pop    FIFO pop strobe (combinational, high only when a pop is taken)
//   out_data    registered word to the array
//   out_valid   out_data valid
//   out_ready   array accepts out_data this cycle
//   busy        high in RUN and DONE
//   done        1-cycle pulse after the last word of a burst is accepted
//   stall_cnt   empty-FIFO stall cycles of the current/last burst

module fifo_burst_reader #(
    parameter int MAX_LEN = 256,
    parameter int DW      = 32,
    localparam int LW     = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic [DW-1:0] fifo_dat,
    input  logic          fifo_empty,
    output logic          fifo_pop,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic [15:0]   stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state;
    logic [LW-1:0] remain;
    logic          take;
    logic          remain_zero;

    assign remain_zero = (remain == '0);

    // A pop is taken only while words are still owed, the FIFO has data and
    // the output register is free or being emptied this same cycle. Gating
    // with RST keeps the FIFO untouched during a reset cycle.
    assign take = (state == S_RUN) && !remain_zero && !fifo_empty &&
                  (!out_valid || out_ready) && !RST;

    assign fifo_pop = take;

    // Burst FSM with registered outputs. In RUN, a take reloads the output
    // register; otherwise an accepted word empties it. The burst completes
    // once nothing is owed and the held word (if any) is accepted.
    always_ff @(posedge clk) begin
        if (RST) begin
            state     <= S_IDLE;
            remain    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (len != '0) begin
                            remain <= len;
                            state  <= S_RUN;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (take) begin
                        out_data  <= fifo_dat;
                        out_valid <= 1'b1;
                        remain    <= remain - LW'(1);
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                    if (remain_zero && (!out_valid || out_ready)) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef BURST_STALL_CNT_EN
    logic [15:0] stall_q;

    // Counts cycles the burst is starved by an empty FIFO while words are
    // still owed; saturates rather than wrapping so long stalls stay visible.
    always_ff @(posedge clk) begin
        if (RST) begin
            stall_q <= 16'h0;
        end else if (state == S_IDLE && start) begin
            stall_q <= 16'h0;
        end else if (state == S_RUN && !remain_zero && fifo_empty &&
                     stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader
//   Self-checking bench for fifo_burst_reader. The FIFO is a queue inside the
//   bench that reacts to the DUT's pops. A cycle-level reference model built
//   from the burst rules predicts every output. On top of that, a table of
//   per-cycle vectors covers the basic 4-word burst, hand-written sequences
//   cover the multi-cycle corner cases, and a long randomized run exercises
//   everything together.

module tb_fifo_burst_reader;

`ifdef BURST_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic        clk;
    logic        RST;
    logic        start;
    logic [8:0]  len;
    logic [31:0] fifo_dat;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [15:0] stall_cnt;

    fifo_burst_reader #(.MAX_LEN(256), .DW(32)) dut (
        .clk        (clk),
        .RST        (RST),
        .start      (start),
        .len        (len),
        .fifo_dat   (fifo_dat),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] fifo_q[$];
    bit          pend_pop = 1'b0;
    int          pop_total = 0;
    int          done_total = 0;

    // Reference model state: 0 idle, 1 run, 2 done.
    int          m_state = 0;
    int          m_remain = 0;
    bit          m_valid = 1'b0;
    logic [31:0] m_data = 32'h0;
    int          m_stall = 0;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: update the FIFO for last cycle's pop, drive inputs on
    // the falling edge, check all outputs against the model, advance it.
    task automatic applyStimulus(input bit r, input bit s, input int l, input bit rdy);
        bit   exp_pop;
        int   o_rem;
        bit   o_valid;
        @(negedge clk);
        if (pend_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
        RST        = r;
        start      = s;
        len        = 9'(l);
        out_ready  = rdy;
        fifo_empty = (fifo_q.size() == 0);
        fifo_dat   = fifo_empty ? 32'hDEADBEEF : fifo_q[0];
        #1;
        exp_pop = !r && m_state == 1 && m_remain > 0 && !fifo_empty && (!m_valid || rdy);
        checkOutput("fifo_pop", 32'(fifo_pop), 32'(exp_pop));
        checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) checkOutput("out_data", out_data, m_data);
        checkOutput("busy", 32'(busy), 32'(m_state != 0));
        checkOutput("done", 32'(done), 32'(m_state == 2));
        checkOutput("stall_cnt", 32'(stall_cnt), STALL_EN ? 32'(m_stall) : 32'h0);
        pend_pop = fifo_pop;
        if (fifo_pop) pop_total++;
        if (done) done_total++;
        if (r) begin
            m_state = 0; m_remain = 0; m_valid = 1'b0; m_data = 32'h0; m_stall = 0;
        end else begin
            case (m_state)
                0: begin
                    if (s) begin
                        m_stall = 0;
                        if (l > 0) begin
                            m_remain = l;
                            m_state  = 1;
                        end else begin
                            m_state = 2;
                        end
                    end
                end
                1: begin
                    o_rem   = m_remain;
                    o_valid = m_valid;
                    if (o_rem > 0 && fifo_empty && m_stall < 65535) m_stall++;
                    if (exp_pop) begin
                        m_data   = fifo_dat;
                        m_valid  = 1'b1;
                        m_remain = m_remain - 1;
                    end else if (o_valid && rdy) begin
                        m_valid = 1'b0;
                    end
                    if (o_rem == 0 && (!o_valid || rdy)) begin
                        m_state = 2;
                        m_valid = 1'b0;
                    end
                end
                default: begin
                    m_state = 0;
                    m_valid = 1'b0;
                end
            endcase
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 0, 1'b1);
        fifo_q.delete();
        pend_pop = 1'b0;
    endtask

    typedef struct {
        bit          rst;
        bit          st;
        int          ln;
        bit          rdy;
        bit          pop;
        bit          vld;
        logic [31:0] dat;
        bit          bsy;
        bit          dn;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int p0, d0, sz;

        tbl[0] = '{1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b1, 32'hA0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b1, 32'hA1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b1, 32'hA2, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 32'hA3, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0};

        RST = 1'b1; start = 1'b0; len = 9'd0; out_ready = 1'b1;
        fifo_empty = 1'b1; fifo_dat = 32'h0;
        repeat (2) @(posedge clk);

        // Reset state
        doReset();
        applyStimulus(1'b0, 1'b0, 0, 1'b1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_out_data", out_data, 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_stall", 32'(stall_cnt), 32'h0);

        // Basic 4-word burst, table driven
        for (int i = 0; i < 4; i++) fifo_q.push_back(32'hA0 + 32'(i));
        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].st, tbl[i].ln, tbl[i].rdy);
            checkOutput($sformatf("tbl%0d_pop", i), 32'(fifo_pop), 32'(tbl[i].pop));
            checkOutput($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].vld));
            if (tbl[i].vld)
                checkOutput($sformatf("tbl%0d_data", i), out_data, tbl[i].dat);
            checkOutput($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
            checkOutput($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].dn));
        end
        checkOutput("t1_fifo_left", 32'(fifo_q.size()), 32'd0);

        // 8 words queued, burst of 3: extra words stay in the FIFO
        doReset();
        for (int i = 0; i < 8; i++) fifo_q.push_back(32'hB0 + 32'(i));
        p0 = pop_total; d0 = done_total;
        applyStimulus(1'b0, 1'b1, 3, 1'b1);
        repeat (8) applyStimulus(1'b0, 1'b0, 0, 1'b1);
        checkOutput("t2_pops", 32'(pop_total - p0), 32'd3);
        checkOutput("t2_dones", 32'(done_total - d0), 32'd1);
        checkOutput("t2_fifo_left", 32'(fifo_q.size()), 32'd5);

        // Back-pressure: out_ready low for 3 cycles after the first word
        doReset();
        for (int i = 0; i < 4; i++) fifo_q.push_back(32'hC0 + 32'(i));
        p0 = pop_total; d0 = done_total;
        applyStimulus(1'b0, 1'b1, 4, 1'b1);
        applyStimulus(1'b0, 1'b0, 0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 0, 1'b0);
            checkOutput("t3_hold_data", out_data, 32'hC0);
            checkOutput("t3_hold_nopop", 32'(fifo_pop), 32'h0);
        end
        repeat (8) applyStimulus(1'b0, 1'b0, 0, 1'b1);
        checkOutput("t3_pops", 32'(pop_total - p0), 32'd4);
        checkOutput("t3_dones", 32'(done_total - d0), 32'd1);

        // Empty FIFO for 5 cycles after the first word
        doReset();
        fifo_q.push_back(32'hD0);
        applyStimulus(1'b0, 1'b1, 3, 1'b1);
        applyStimulus(1'b0, 1'b0, 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 0, 1'b1);
            checkOutput("t4_nopop", 32'(fifo_pop), 32'h0);
            if (i > 0) checkOutput("t4_valid_low", 32'(out_valid), 32'h0);
        end
        fifo_q.push_back(32'hD1);
        fifo_q.push_back(32'hD2);
        repeat (8) applyStimulus(1'b0, 1'b0, 0, 1'b1);
        checkOutput("t4_stall", 32'(stall_cnt), STALL_EN ? 32'd5 : 32'd0);
        checkOutput("t4_busy_end", 32'(busy), 32'h0);

        // Zero-length burst, then start pulses ignored during RUN
        doReset();
        applyStimulus(1'b0, 1'b1, 0, 1'b1);
        applyStimulus(1'b0, 1'b0, 0, 1'b1);
        checkOutput("t5_done", 32'(done), 32'h1);
        checkOutput("t5_nopop", 32'(fifo_pop), 32'h0);
        applyStimulus(1'b0, 1'b0, 0, 1'b1);
        checkOutput("t5_done_once", 32'(done), 32'h0);
        checkOutput("t5_idle", 32'(busy), 32'h0);
        p0 = pop_total;
        applyStimulus(1'b0, 1'b1, 3, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b1, 7, 1'b1);
        for (int i = 0; i < 5; i++) fifo_q.push_back(32'hE0 + 32'(i));
        repeat (8) applyStimulus(1'b0, 1'b0, 0, 1'b1);
        checkOutput("t5_pops", 32'(pop_total - p0), 32'd3);
        checkOutput("t5_fifo_left", 32'(fifo_q.size()), 32'd2);

        // Reset mid-burst with a word held
        doReset();
        for (int i = 0; i < 4; i++) fifo_q.push_back(32'hF0 + 32'(i));
        applyStimulus(1'b0, 1'b1, 4, 1'b1);
        applyStimulus(1'b0, 1'b0, 0, 1'b1);
        applyStimulus(1'b0, 1'b0, 0, 1'b1);
        applyStimulus(1'b1, 1'b0, 0, 1'b1);
        checkOutput("t6_rst_nopop", 32'(fifo_pop), 32'h0);
        sz = fifo_q.size();
        applyStimulus(1'b0, 1'b0, 0, 1'b1);
        checkOutput("t6_valid", 32'(out_valid), 32'h0);
        checkOutput("t6_busy", 32'(busy), 32'h0);
        checkOutput("t6_nopop", 32'(fifo_pop), 32'h0);
        checkOutput("t6_fifo_ocp", 32'(fifo_q.size()), 32'(sz));

        // Randomized traffic against the model
        doReset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 12) fifo_q.push_back($urandom);
            applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
                          int'($urandom_range(0, 6)), $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
